// File: rtl/cgra_pkg.sv
// Shared definitions for the CGRA processing element: opcodes, FSM states,
// instruction field positions and the ALU function.
package cgra_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_SLL  = 4'd3,
    OP_SRL  = 4'd4,
    OP_SLT  = 4'd5,
    OP_SEQ  = 4'd6,
    OP_OR   = 4'd7,
    OP_AND  = 4'd8,
    OP_LDI  = 4'd9,
    OP_SEND = 4'd10,
    OP_RECV = 4'd11,
    OP_OUT  = 4'd12,
    OP_BRZ  = 4'd13,
    OP_NOP  = 4'd14,
    OP_HALT = 4'd15
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_WAIT_RX,
    ST_WAIT_TX,
    ST_HALT
  } state_e;

  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned F_OP_LSB   = 28;
  localparam int unsigned F_RD_LSB   = 24;
  localparam int unsigned F_RS1_LSB  = 20;
  localparam int unsigned F_RS2_LSB  = 16;
  localparam int unsigned F_PORT_LSB = 13;
  localparam int unsigned F_IMM_LSB  = 0;
  localparam int unsigned F_OP_W     = 4;
  localparam int unsigned F_REG_W    = 4;
  localparam int unsigned F_PORT_W   = 3;
  localparam int unsigned F_IMM_W    = 16;

  // Operands arrive zero-extended to this width and the caller truncates the
  // result, so one function serves every DATA_W up to 64.
  localparam int unsigned ALU_W = 64;

  function automatic logic [ALU_W-1:0] alu_f(input op_e op,
                                             input logic [ALU_W-1:0] a,
                                             input logic [ALU_W-1:0] b);
    logic [ALU_W-1:0] y;
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_MUL:  y = ALU_W'(a[15:0]) * ALU_W'(b[15:0]);
      OP_SLL:  y = a << b[4:0];
      OP_SRL:  y = a >> b[4:0];
      OP_SLT:  y = ALU_W'(a < b);
      OP_SEQ:  y = ALU_W'(a == b);
      OP_OR:   y = a | b;
      OP_AND:  y = a & b;
      default: y = '0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/cgra_pe_alu.sv
// Combinational ALU of the processing element.
module cgra_pe_alu
  import cgra_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [3:0]        i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_y
);

  // Evaluate the shared ALU function and truncate to the datapath width.
  always_comb begin
    o_y = DATA_W'(alu_f(op_e'(i_op), ALU_W'(i_a), ALU_W'(i_b)));
  end

endmodule

// File: rtl/cgra_pe.sv
// Self-sequencing CGRA processing element: program memory, pc, register
// file, ALU and NPORTS valid/ready neighbour channels.
module cgra_pe
  import cgra_pkg::*;
#(
  parameter  int unsigned DATA_W     = 32,
  parameter  int unsigned NREGS      = 8,
  parameter  int unsigned NPORTS     = 4,
  parameter  int unsigned IMEM_DEPTH = 16,
  localparam int unsigned IMEM_AW    = $clog2(IMEM_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_we,
  input  logic [IMEM_AW-1:0]       cfg_addr,
  input  logic [31:0]              cfg_data,
  input  logic                     start,
  output logic                     busy,
  output logic                     halted,
  input  logic [NPORTS*DATA_W-1:0] in_data,
  input  logic [NPORTS-1:0]        in_valid,
  output logic [NPORTS-1:0]        in_ready,
  output logic [NPORTS*DATA_W-1:0] out_data,
  output logic [NPORTS-1:0]        out_valid,
  input  logic [NPORTS-1:0]        out_ready,
  output logic [DATA_W-1:0]        final_output,
  output logic                     final_valid
);

  localparam int unsigned RIDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  state_e                    r_state;
  logic [IMEM_AW-1:0]        r_pc;
  logic [INSTR_W-1:0]        r_imem [IMEM_DEPTH];
  logic [DATA_W-1:0]         r_regs [NREGS];
  logic [NPORTS*DATA_W-1:0]  r_out_data;
  logic [NPORTS-1:0]         r_out_valid;
  logic [DATA_W-1:0]         r_final_output;
  logic                      r_final_valid;

  logic [INSTR_W-1:0]        w_instr;
  logic [3:0]                w_op_raw;
  op_e                       w_op;
  logic [RIDX_W-1:0]         w_rd, w_rs1, w_rs2;
  logic [F_PORT_W-1:0]       w_port;
  logic [F_IMM_W-1:0]        w_imm;
  logic [DATA_W-1:0]         w_imm_sext, w_rs1_val, w_rs2_val, w_alu_y;
  logic [DATA_W-1:0]         w_sel_in_data;
  logic [IMEM_AW-1:0]        w_pc_inc;
  logic [NPORTS-1:0]         w_port_sel;
  logic                      w_port_ok, w_sel_in_valid, w_sel_out_ready, w_sel_out_valid;

  // Register fields are 4 bits wide; fold them onto the implemented registers.
  function automatic logic [RIDX_W-1:0] reg_idx(input logic [3:0] f);
    logic [4:0] m;
    m = {1'b0, f} % 5'(NREGS);
    return RIDX_W'(m);
  endfunction

  // Fetch and decode the instruction at pc.
  always_comb begin
    w_instr    = r_imem[r_pc];
    w_op_raw   = w_instr[F_OP_LSB +: F_OP_W];
    w_op       = op_e'(w_op_raw);
    w_rd       = reg_idx(w_instr[F_RD_LSB +: F_REG_W]);
    w_rs1      = reg_idx(w_instr[F_RS1_LSB +: F_REG_W]);
    w_rs2      = reg_idx(w_instr[F_RS2_LSB +: F_REG_W]);
    w_port     = w_instr[F_PORT_LSB +: F_PORT_W];
    w_imm      = w_instr[F_IMM_LSB +: F_IMM_W];
    w_imm_sext = DATA_W'(signed'(w_imm));
    w_rs1_val  = r_regs[w_rs1];
    w_rs2_val  = r_regs[w_rs2];
    w_pc_inc   = r_pc + IMEM_AW'(1);
  end

  // One-hot port select; an out-of-range port field selects nothing.
  always_comb begin
    w_port_sel    = '0;
    w_sel_in_data = '0;
    for (int unsigned p = 0; p < NPORTS; p++) begin
      if (w_port == 3'(p)) begin
        w_port_sel[p] = 1'b1;
        w_sel_in_data = in_data[p*DATA_W +: DATA_W];
      end
    end
    w_port_ok       = |w_port_sel;
    w_sel_in_valid  = |(in_valid & w_port_sel);
    w_sel_out_ready = |(out_ready & w_port_sel);
    w_sel_out_valid = |(r_out_valid & w_port_sel);
  end

  cgra_pe_alu #(.DATA_W(DATA_W)) u_alu (
    .i_op (w_op_raw),
    .i_a  (w_rs1_val),
    .i_b  (w_rs2_val),
    .o_y  (w_alu_y)
  );

  // Status flags and channel ready, decoded from the registered state.
  always_comb begin
    busy     = (r_state == ST_RUN) || (r_state == ST_WAIT_RX) || (r_state == ST_WAIT_TX);
    halted   = (r_state == ST_HALT);
    in_ready = '0;
    if (((r_state == ST_RUN) || (r_state == ST_WAIT_RX)) && (w_op == OP_RECV))
      in_ready = w_port_sel;
    out_data     = r_out_data;
    out_valid    = r_out_valid;
    final_output = r_final_output;
    final_valid  = r_final_valid;
  end

  // Program memory writes, accepted only while the PE is not executing.
  always_ff @(posedge clk) begin
    if (cfg_we && ((r_state == ST_IDLE) || (r_state == ST_HALT)))
      r_imem[cfg_addr] <= cfg_data;
  end

  // Sequencer, register file and channel state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_pc           <= '0;
      r_out_data     <= '0;
      r_out_valid    <= '0;
      r_final_output <= '0;
      r_final_valid  <= 1'b0;
      for (int unsigned i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      r_final_valid <= 1'b0;
      case (r_state)
        ST_IDLE, ST_HALT: begin
          if (start) begin
            r_state <= ST_RUN;
            r_pc    <= '0;
          end
        end
        ST_RUN: begin
          case (w_op)
            OP_ADD, OP_SUB, OP_MUL, OP_SLL, OP_SRL, OP_SLT, OP_SEQ, OP_OR, OP_AND: begin
              r_regs[w_rd] <= w_alu_y;
              r_pc         <= w_pc_inc;
            end
            OP_LDI: begin
              r_regs[w_rd] <= w_imm_sext;
              r_pc         <= w_pc_inc;
            end
            OP_SEND: begin
              if (!w_port_ok) begin
                r_pc <= w_pc_inc;
              end else if (!w_sel_out_valid) begin
                for (int unsigned p = 0; p < NPORTS; p++) begin
                  if (w_port_sel[p]) begin
                    r_out_data[p*DATA_W +: DATA_W] <= w_rs1_val;
                    r_out_valid[p]                 <= 1'b1;
                  end
                end
                r_state <= ST_WAIT_TX;
              end
            end
            OP_RECV: begin
              if (!w_port_ok) begin
                r_pc <= w_pc_inc;
              end else if (w_sel_in_valid) begin
                r_regs[w_rd] <= w_sel_in_data;
                r_pc         <= w_pc_inc;
              end else begin
                r_state <= ST_WAIT_RX;
              end
            end
            OP_OUT: begin
              r_final_output <= w_rs1_val;
              r_final_valid  <= 1'b1;
              r_pc           <= w_pc_inc;
            end
            OP_BRZ: begin
              if (w_rs1_val == '0) r_pc <= w_imm[IMEM_AW-1:0];
              else                 r_pc <= w_pc_inc;
            end
            OP_HALT: r_state <= ST_HALT;
            default: r_pc <= w_pc_inc;
          endcase
        end
        ST_WAIT_RX: begin
          if (w_sel_in_valid) begin
            r_regs[w_rd] <= w_sel_in_data;
            r_pc         <= w_pc_inc;
            r_state      <= ST_RUN;
          end
        end
        ST_WAIT_TX: begin
          if (w_sel_out_ready) begin
            r_out_valid <= r_out_valid & ~w_port_sel;
            r_pc        <= w_pc_inc;
            r_state     <= ST_RUN;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cgra_pe.sv
// Self-checking bench for cgra_pe: directed channel/reset scenarios plus
// random programs compared against an instruction-level interpreter.
module tb_cgra_pe;

  localparam int DW = 32;
  localparam int NP = 4;

  logic           clk = 1'b0;
  logic           rst, cfg_we, start;
  logic [3:0]     cfg_addr;
  logic [31:0]    cfg_data;
  logic           busy, halted;
  logic [NP*DW-1:0] in_data, out_data;
  logic [NP-1:0]  in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0]  final_output;
  logic           final_valid;

  cgra_pe #(.DATA_W(DW), .NREGS(8), .NPORTS(NP), .IMEM_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .busy(busy), .halted(halted),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .final_output(final_output), .final_valid(final_valid)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [31:0] val; } ev_t;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] prog [16];
  ev_t         got_q[$];
  ev_t         exp_q[$];
  int          exp_halt;
  int          halt_cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc(input int op, input int rd, input int rs1,
                                      input int rs2, input int imm);
    return {op[3:0], rd[3:0], rs1[3:0], rs2[3:0], imm[15:0]};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic load_prog();
    for (int a = 0; a < 16; a++) begin
      cfg_we   = 1'b1;
      cfg_addr = 4'(a);
      cfg_data = prog[a];
      tick();
    end
    cfg_we = 1'b0;
  endtask

  // Pulse start, then record every final_valid cycle until halted or budget.
  task automatic run_collect(input int budget);
    ev_t e;
    got_q.delete();
    halt_cyc = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      tick();
      if (final_valid) begin
        e.cyc = cyc;
        e.val = final_output;
        got_q.push_back(e);
      end
      if (halted) begin
        halt_cyc = cyc;
        break;
      end
    end
  endtask

  // Instruction-level interpreter: one instruction per cycle, OUT observed in
  // the cycle it executes, registers start at zero after reset.
  task automatic model_run();
    logic [31:0] r [8];
    logic [31:0] ins, va, vb;
    int          pc, npc, op, rd, a, b;
    ev_t         e;
    foreach (r[i]) r[i] = '0;
    pc = 0;
    exp_q.delete();
    exp_halt = -1;
    for (int step = 1; step <= 300; step++) begin
      ins = prog[pc];
      op  = int'(ins[31:28]);
      rd  = int'(ins[27:24]) % 8;
      a   = int'(ins[23:20]) % 8;
      b   = int'(ins[19:16]) % 8;
      va  = r[a];
      vb  = r[b];
      npc = (pc + 1) % 16;
      case (op)
        0:  r[rd] = va + vb;
        1:  r[rd] = va - vb;
        2:  r[rd] = (va & 32'hFFFF) * (vb & 32'hFFFF);
        3:  r[rd] = va << (vb % 32);
        4:  r[rd] = va >> (vb % 32);
        5:  r[rd] = (va < vb) ? 32'd1 : 32'd0;
        6:  r[rd] = (va == vb) ? 32'd1 : 32'd0;
        7:  r[rd] = va | vb;
        8:  r[rd] = va & vb;
        9:  r[rd] = {{16{ins[15]}}, ins[15:0]};
        12: begin e.cyc = step; e.val = va; exp_q.push_back(e); end
        13: if (va == 0) npc = int'(ins[3:0]);
        15: begin exp_halt = step; return; end
        default: ;
      endcase
      pc = npc;
    end
  endtask

  task automatic compare_model(input string tag);
    chk({tag, "_nout"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk({tag, "_val"}, 64'(got_q[i].val), 64'(exp_q[i].val));
      chk({tag, "_cyc"}, 64'(got_q[i].cyc), 64'(exp_q[i].cyc));
    end
    chk({tag, "_halt"}, 64'(halt_cyc), 64'(exp_halt));
  endtask

  function automatic logic [31:0] first_val();
    return (got_q.size() > 0) ? got_q[0].val : 32'hx;
  endfunction

  initial begin
    logic [31:0] d;
    logic [31:0] pw;
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; start = 1'b0;
    in_data = '0; in_valid = '0; out_ready = '0;
    tick();
    tick();
    // Reset state while rst is held.
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_halted", 64'(halted), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'(out_data[63:0]), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_final", 64'({final_valid, final_output}), 64'(0));
    rst = 1'b0;
    tick();

    // LDI/LDI/ADD/OUT/HALT.
    foreach (prog[i]) prog[i] = enc(14, 0, 0, 0, 0);
    prog[0] = enc(9, 1, 0, 0, 5);
    prog[1] = enc(9, 2, 0, 0, 7);
    prog[2] = enc(0, 3, 1, 2, 0);
    prog[3] = enc(12, 0, 3, 0, 0);
    prog[4] = enc(15, 0, 0, 0, 0);
    load_prog();
    run_collect(50);
    chk("add_nout", 64'(got_q.size()), 64'(1));
    chk("add_val", 64'(first_val()), 64'(12));
    chk("add_cyc", 64'((got_q.size() > 0) ? got_q[0].cyc : -1), 64'(4));
    chk("add_halt", 64'(halt_cyc), 64'(5));
    chk("add_halted", 64'(halted), 64'(1));

    // Sign-extended LDI and ADD wrap.
    do_reset();
    foreach (prog[i]) prog[i] = enc(14, 0, 0, 0, 0);
    prog[0] = enc(9, 1, 0, 0, 16'hFFFF);
    prog[1] = enc(0, 2, 1, 1, 0);
    prog[2] = enc(12, 0, 2, 0, 0);
    prog[3] = enc(15, 0, 0, 0, 0);
    load_prog();
    run_collect(50);
    chk("wrap_val", 64'(first_val()), 64'(32'hFFFF_FFFE));

    // SEND on port 2 held off for five cycles by its own ready.
    do_reset();
    foreach (prog[i]) prog[i] = enc(14, 0, 0, 0, 0);
    prog[0] = enc(9, 1, 0, 0, 16'hA5);
    prog[1] = enc(10, 0, 1, 0, 2 << 13);
    prog[2] = enc(9, 5, 0, 0, 9);
    prog[3] = enc(12, 0, 5, 0, 0);
    prog[4] = enc(15, 0, 0, 0, 0);
    load_prog();
    out_ready = 4'b1011;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    tick();
    chk("tx_load_valid", 64'(out_valid), 64'(4'b0100));
    chk("tx_load_data", 64'(out_data[95:64]), 64'(32'hA5));
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("tx_hold_valid", 64'(out_valid), 64'(4'b0100));
      chk("tx_hold_busy", 64'({busy, final_valid}), 64'(2'b10));
    end
    out_ready = 4'b0100;
    tick();
    out_ready = 4'b0000;
    chk("tx_accept_valid", 64'(out_valid), 64'(0));
    tick();
    chk("tx_no_early_out", 64'(final_valid), 64'(0));
    tick();
    chk("tx_out", 64'({final_valid, final_output}), 64'({1'b1, 32'd9}));
    tick();
    chk("tx_halt_pulse", 64'({halted, final_valid}), 64'(2'b10));

    // RECV on port 1 with data arriving three cycles late.
    do_reset();
    foreach (prog[i]) prog[i] = enc(14, 0, 0, 0, 0);
    prog[0] = enc(11, 4, 0, 0, 1 << 13);
    prog[1] = enc(12, 0, 4, 0, 0);
    prog[2] = enc(15, 0, 0, 0, 0);
    load_prog();
    in_data  = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 4'b1101;
    start = 1'b1; tick(); start = 1'b0;
    chk("rx_ready_first", 64'(in_ready), 64'(4'b0010));
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rx_ready_wait", 64'(in_ready), 64'(4'b0010));
    end
    d = $urandom;
    pw = $urandom;
    in_data  = {pw, ~pw, d, pw ^ 32'h5A5A_5A5A};
    in_valid = 4'b1111;
    tick();
    in_valid = 4'b0000;
    chk("rx_ready_after", 64'(in_ready), 64'(0));
    tick();
    chk("rx_out", 64'({final_valid, final_output}), 64'({1'b1, d}));

    // Countdown loop: three iterations, exit through BRZ.
    do_reset();
    foreach (prog[i]) prog[i] = enc(14, 0, 0, 0, 0);
    prog[0] = enc(9, 1, 0, 0, 3);
    prog[1] = enc(9, 2, 0, 0, 1);
    prog[2] = enc(1, 1, 1, 2, 0);
    prog[3] = enc(12, 0, 1, 0, 0);
    prog[4] = enc(13, 0, 1, 0, 6);
    prog[5] = enc(13, 0, 0, 0, 2);
    prog[6] = enc(15, 0, 0, 0, 0);
    load_prog();
    model_run();
    run_collect(100);
    chk("loop_iters", 64'(got_q.size()), 64'(3));
    compare_model("loop");

    // pc wraps from 15 back to 0.
    do_reset();
    foreach (prog[i]) prog[i] = enc(14, 0, 0, 0, 0);
    prog[0]  = enc(13, 0, 6, 0, 14);
    prog[1]  = enc(12, 0, 6, 0, 0);
    prog[2]  = enc(15, 0, 0, 0, 0);
    prog[14] = enc(9, 6, 0, 0, 16'h77);
    load_prog();
    model_run();
    run_collect(100);
    chk("pcwrap_val", 64'(first_val()), 64'(32'h77));
    compare_model("pcwrap");

    // Random straight-line programs with forward branches.
    for (int t = 0; t < 6; t++) begin
      do_reset();
      for (int a = 0; a < 15; a++) begin
        int kind;
        kind = (a < 3) ? 9 : int'($urandom_range(0, 12));
        case (kind)
          10: prog[a] = enc(12, 0, int'($urandom_range(0, 15)), 0, 0);
          11: prog[a] = enc(13, 0, int'($urandom_range(0, 15)), 0,
                            int'({$urandom_range(0, 4095), 4'($urandom_range(a + 1, 15))}));
          12: prog[a] = enc(14, 0, 0, 0, 0);
          default: prog[a] = enc(kind, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                                 int'($urandom_range(0, 15)), int'($urandom_range(0, 65535)));
        endcase
      end
      prog[14] = enc(12, 0, int'($urandom_range(0, 15)), 0, 0);
      prog[15] = enc(15, 0, 0, 0, 0);
      load_prog();
      model_run();
      run_collect(100);
      compare_model("rand");
    end

    // Reset while a SEND waits for ready, then re-run from pc 0.
    do_reset();
    foreach (prog[i]) prog[i] = enc(14, 0, 0, 0, 0);
    prog[0] = enc(9, 1, 0, 0, 16'hA5);
    prog[1] = enc(12, 0, 1, 0, 0);
    prog[2] = enc(10, 0, 1, 0, 2 << 13);
    prog[3] = enc(15, 0, 0, 0, 0);
    load_prog();
    out_ready = 4'b0000;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick(); tick();
    chk("ar_pre_state", 64'({busy, out_valid, final_output}), 64'({1'b1, 4'b0100, 32'hA5}));
    #2 rst = 1'b1;
    #1;
    chk("ar_out_valid", 64'(out_valid), 64'(0));
    chk("ar_out_data", 64'(out_data[95:64]), 64'(0));
    chk("ar_flags", 64'({busy, halted, in_ready, final_valid}), 64'(0));
    chk("ar_final_output", 64'(final_output), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    tick();
    out_ready = 4'b1111;
    run_collect(50);
    chk("ar_rerun_nout", 64'(got_q.size()), 64'(1));
    chk("ar_rerun_val", 64'(first_val()), 64'(32'hA5));
    chk("ar_rerun_cyc", 64'((got_q.size() > 0) ? got_q[0].cyc : -1), 64'(2));
    chk("ar_rerun_halt", 64'(halt_cyc), 64'(5));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
